// File: rtl/comar_and_scheduler.sv
// Round-robin scheduler sharing one 2-share COMAR AND gadget between N_REQ
// requesters. It supplies fresh masks from an internal LFSR (with seed load
// and warm-up) and carries requester ID/valid through the gadget's 2-cycle
// latency so each result returns to the requester that issued it.
module comar_and_scheduler #(
    parameter int          N_REQ         = 4,
    parameter int          ID_W          = 2,
    parameter int          WARMUP_CYCLES = 16,
    parameter logic [15:0] SEED_DEFAULT  = 16'hACE1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_seed_load,
    input  logic [15:0]          i_seed,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [2*N_REQ-1:0]   i_req_a,
    input  logic [2*N_REQ-1:0]   i_req_b,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [1:0]           o_g_a,
    output logic [1:0]           o_g_b,
    output logic [5:0]           o_g_r,
    input  logic [1:0]           i_g_c,
    output logic                 o_rsp_valid,
    output logic [ID_W-1:0]      o_rsp_id,
    output logic [1:0]           o_rsp_c,
    output logic                 o_ready
);

    localparam int STAGES = 2;
    localparam int CNT_W  = $clog2(WARMUP_CYCLES + 1);

    typedef enum logic {S_WARMUP, S_RUN} state_t;

    state_t                      r_state, w_state_nxt;
    logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
    logic [15:0]                 r_lfsr, w_lfsr_nxt;
    logic [ID_W-1:0]             r_ptr;
    logic [STAGES:1]             r_vld_pipe;
    logic [STAGES:1][ID_W-1:0]   r_id_pipe;

    logic                        w_hit;
    logic                        w_issue;
    logic [ID_W-1:0]             w_win;
    logic [ID_W-1:0]             w_cand;
    logic [ID_W:0]               w_idx;

    // Six unrolled steps of x^16+x^14+x^13+x^11+1 (right-shifting Fibonacci);
    // bit 0 is the bit shifted out on each step.
    function automatic logic [15:0] lfsr_adv6(input logic [15:0] s);
        logic [15:0] v;
        v = s;
        for (int k = 0; k < 6; k++)
            v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v;
    endfunction

    // Bits shifted out by the six steps of this cycle are s[5:0], so the
    // mask word is a pure function of the current state.
    assign o_g_r = r_lfsr[5:0];

    // A zero seed would lock the LFSR, so it is replaced by the default.
    assign w_lfsr_nxt = i_seed_load ? ((i_seed == 16'h0) ? SEED_DEFAULT : i_seed)
                                    : lfsr_adv6(r_lfsr);

    // FSM state and warm-up counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_WARMUP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: seed load always restarts warm-up; warm-up ends after
    // WARMUP_CYCLES discarded LFSR steps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_seed_load) begin
            w_state_nxt = S_WARMUP;
            w_cnt_nxt   = '0;
        end else if (r_state == S_WARMUP) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WARMUP_CYCLES - 1))
                w_state_nxt = S_RUN;
        end
    end

    // LFSR register; advances every cycle in both states.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_lfsr <= SEED_DEFAULT;
        else       r_lfsr <= w_lfsr_nxt;
    end

    // Round-robin search: scan upward from the pointer with wrap, first
    // asserted request wins.
    always_comb begin
        w_hit  = 1'b0;
        w_win  = '0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (ID_W+1)'(r_ptr) + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_REQ))
                w_idx = w_idx - (ID_W+1)'(N_REQ);
            w_cand = w_idx[ID_W-1:0];
            if (!w_hit && i_req[w_cand]) begin
                w_hit = 1'b1;
                w_win = w_cand;
            end
        end
    end

    // Seed load wins over a same-cycle grant.
    assign w_issue = (r_state == S_RUN) && !i_seed_load && w_hit;

    // One-hot grant and operand mux to the gadget; zero when idle.
    always_comb begin
        o_gnt = '0;
        o_g_a = '0;
        o_g_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_issue && (w_win == ID_W'(i))) begin
                o_gnt[i] = 1'b1;
                o_g_a    = i_req_a[2*i +: 2];
                o_g_b    = i_req_b[2*i +: 2];
            end
        end
    end

    // Pointer moves past the winner; unchanged on idle cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ptr <= '0;
        else if (w_issue)
            r_ptr <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
    end

    // Valid/ID shift register matching the gadget latency; reset drops
    // anything in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_issue};
            r_id_pipe  <= {r_id_pipe[STAGES-1:1], w_win & {ID_W{w_issue}}};
        end
    end

    assign o_rsp_valid = r_vld_pipe[STAGES];
    assign o_rsp_id    = r_id_pipe[STAGES];
    assign o_rsp_c     = i_g_c;
    assign o_ready     = (r_state == S_RUN);

endmodule

// File: tb/tb_comar_and_scheduler.sv
// Bench for comar_and_scheduler: directed phases plus randomized traffic,
// checked against a cycle-level reference model and an external gadget stand-in.
module tb_comar_and_scheduler;

    localparam int N = 4;

    logic             i_clk, i_rst, i_seed_load;
    logic [15:0]      i_seed;
    logic [N-1:0]     i_req;
    logic [2*N-1:0]   i_req_a, i_req_b;
    logic [N-1:0]     o_gnt;
    logic [1:0]       o_g_a, o_g_b, i_g_c, o_rsp_c;
    logic [5:0]       o_g_r;
    logic             o_rsp_valid, o_ready;
    logic [1:0]       o_rsp_id;

    comar_and_scheduler dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_seed_load(i_seed_load), .i_seed(i_seed),
        .i_req(i_req), .i_req_a(i_req_a), .i_req_b(i_req_b), .o_gnt(o_gnt),
        .o_g_a(o_g_a), .o_g_b(o_g_b), .o_g_r(o_g_r), .i_g_c(i_g_c),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_c(o_rsp_c),
        .o_ready(o_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct { int due; int id; logic c; } rsp_t;
    typedef struct { int due; logic [1:0] sh; } gad_t;

    rsp_t        exp_q[$];
    gad_t        gad_q[$];
    int          ncmp = 0, nfail = 0, cyc = 0;
    int          warm = 16, mptr = 0;
    logic [15:0] mlfsr = 16'hACE1;

    logic [N-1:0] last_gnt;
    logic         last_ready, last_rsp_valid;
    logic [1:0]   last_rsp_id, last_rsp_c;
    logic [5:0]   last_gr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One LFSR step: shift right, feedback from taps 16,14,13,11 (bits 0,2,3,5).
    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // One clock of the reference model. Inputs are set by the caller.
    task automatic step();
        logic       run;
        int         w, idx;
        logic [5:0] gr;
        logic [15:0] s;
        logic       c, m;
        rsp_t       e;
        gad_t       g;
        i_g_c = 2'($urandom);
        if (gad_q.size() > 0 && gad_q[0].due == cyc) begin
            g = gad_q.pop_front();
            i_g_c = g.sh;
        end
        @(negedge i_clk);
        if (i_rst) begin
            exp_q.delete(); gad_q.delete();
            warm = 16; mptr = 0; mlfsr = 16'hACE1;
        end
        run = (warm == 0) && !i_rst;
        w = -1;
        if (run && !i_seed_load)
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (w < 0 && i_req[idx]) w = idx;
            end
        s = mlfsr;
        for (int k = 0; k < 6; k++) begin gr[k] = s[0]; s = lstep(s); end
        last_gnt = o_gnt; last_ready = o_ready; last_gr = o_g_r;
        last_rsp_valid = o_rsp_valid; last_rsp_id = o_rsp_id; last_rsp_c = o_rsp_c;
        chk("gnt", o_gnt, (w >= 0) ? (32'd1 << w) : 32'd0);
        chk("ready", o_ready, run);
        chk("g_a", o_g_a, (w >= 0) ? i_req_a[2*w +: 2] : 2'b00);
        chk("g_b", o_g_b, (w >= 0) ? i_req_b[2*w +: 2] : 2'b00);
        chk("g_r", o_g_r, gr);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rsp_valid", o_rsp_valid, 1);
            chk("rsp_id", o_rsp_id, e.id);
            chk("rsp_c_pass", o_rsp_c, i_g_c);
            chk("rsp_xor", ^o_rsp_c, e.c);
        end else begin
            chk("rsp_idle", o_rsp_valid, 0);
            if (i_rst) chk("rsp_id_rst", o_rsp_id, 0);
        end
        if (w >= 0) begin
            exp_q.push_back('{cyc + 2, w, (^i_req_a[2*w +: 2]) & (^i_req_b[2*w +: 2])});
            c = (^o_g_a) & (^o_g_b);
            m = 1'($urandom);
            gad_q.push_back('{cyc + 2, {m, m ^ c}});
        end
        @(posedge i_clk);
        if (i_rst) begin
            exp_q.delete(); gad_q.delete();
            warm = 16; mptr = 0; mlfsr = 16'hACE1;
        end else begin
            if (i_seed_load) begin
                mlfsr = (i_seed == 16'h0) ? 16'hACE1 : i_seed;
                warm = 16;
            end else begin
                for (int k = 0; k < 6; k++) mlfsr = lstep(mlfsr);
                if (warm > 0) warm--;
            end
            if (w >= 0) mptr = (w + 1) % N;
        end
        cyc++;
        #1;
    endtask

    initial begin
        int n, nops;
        i_rst = 1'b1; i_seed_load = 1'b0; i_seed = '0;
        i_req = '1; i_req_a = 8'hA5; i_req_b = 8'h3C; i_g_c = '0;

        // Reset held: no grants, no responses, zero operands
        repeat (3) step();
        chk("rst_gnt", last_gnt, 0);
        i_rst = 1'b0; i_req = '0;

        // Warm-up: ready low for exactly 16 cycles
        n = 0;
        do begin
            step();
            if (!last_ready) n++;
        end while (!last_ready && n < 40);
        chk("warmup_len", n, 16);

        // Single request from requester 2: a=1 (shares 1,0), b=0 (shares 1,1)
        i_req = 4'b0100; i_req_a = 8'b00_10_00_00; i_req_b = 8'b00_11_00_00;
        step();
        chk("single_gnt", last_gnt, 4'b0100);
        i_req = '0;
        step(); step();
        chk("single_rsp_valid", last_rsp_valid, 1);
        chk("single_rsp_id", last_rsp_id, 2);
        chk("single_rsp_xor", ^last_rsp_c, 0);

        // Reset with two operations in flight
        i_req = '1; i_req_a = 8'($urandom); i_req_b = 8'($urandom);
        step(); step();
        #2 i_rst = 1'b1;
        #1;
        chk("async_gnt", o_gnt, 0);
        chk("async_rsp_valid", o_rsp_valid, 0);
        chk("async_ready", o_ready, 0);
        step();
        i_rst = 1'b0;
        repeat (16) step();

        // All four requesting: order 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_order", last_gnt, 4'b0001 << (k % 4));
        end

        // Seed load (seed 0) with two operations in flight
        step(); step();
        i_seed_load = 1'b1; i_seed = 16'h0;
        step();
        chk("load_no_gnt", last_gnt, 0);
        chk("load_rsp1", last_rsp_valid, 1);
        i_seed_load = 1'b0;
        step();
        chk("load_rsp2", last_rsp_valid, 1);
        chk("load_gr", last_gr, 6'h21);
        n = 1;
        while (!last_ready && n < 40) begin
            step();
            if (!last_ready) n++;
        end
        chk("reload_warmup_len", n, 16);

        // Random traffic with occasional reseeds
        nops = 0;
        for (int k = 0; k < 4000 && nops < 1000; k++) begin
            i_req   = 4'($urandom_range(0, 15));
            i_req_a = 8'($urandom);
            i_req_b = 8'($urandom);
            i_seed_load = ($urandom_range(0, 299) == 0);
            i_seed = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
            step();
            if (last_gnt != 0) nops++;
        end
        chk("random_ops_done", nops >= 1000, 1);
        i_req = '0; i_seed_load = 1'b0;
        repeat (4) step();
        chk("drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
